// File: rtl/reg_file_sb_if.sv
// Register file / scoreboard bus: read ports, reservation request and
// writeback channel. The core side drives the master modport and the
// register file sits on the slave modport.
interface reg_file_sb_if #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32,
    parameter int NRD   = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_val;
    logic [NRD-1:0]      rd_ready;
    logic                rsv_sig;
    logic [AW-1:0]       rsv_reg;
    logic                rsv_ack;
    logic                write_sig;
    logic [AW-1:0]       write_reg;
    logic [XLEN-1:0]     write_val;
    logic                wr_err;

    modport master (
        output rd_addr, rsv_sig, rsv_reg, write_sig, write_reg, write_val,
        input  rd_val, rd_ready, rsv_ack, wr_err
    );

    modport slave (
        input  rd_addr, rsv_sig, rsv_reg, write_sig, write_reg, write_val,
        output rd_val, rd_ready, rsv_ack, wr_err
    );
endinterface

// File: rtl/reg_file_sb.sv
// Register file with a per-register 2-bit saturating pending-write
// scoreboard. Register 0 is hardwired to zero. Reads are combinational.
// Optional feature: define REG_FILE_BYPASS_EN to forward a same-cycle
// writeback onto matching read ports.
module reg_file_sb #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32,
    parameter int NRD   = 2
) (
    input logic          clk,
    input logic          reset,
    reg_file_sb_if.slave bus
);
    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]  regs [NREGS];
    logic [1:0]       cnt  [NREGS];
    logic             wb_valid;
    logic             err_next;
    logic [NREGS-1:0] inc_vec;
    logic [NREGS-1:0] dec_vec;
    logic [AW-1:0]    rd_idx;

    // A writeback only counts when out of reset and not aimed at x0.
    assign wb_valid = reset && bus.write_sig && (bus.write_reg != '0);

    // Accept a reservation if the counter has room or a same-register writeback frees a slot now.
    always_comb begin
        bus.rsv_ack = 1'b0;
        if (reset && bus.rsv_sig) begin
            if (bus.rsv_reg == '0)
                bus.rsv_ack = 1'b1;
            else if (cnt[bus.rsv_reg] != 2'd3)
                bus.rsv_ack = 1'b1;
            else if (bus.write_sig && (bus.write_reg == bus.rsv_reg))
                bus.rsv_ack = 1'b1;
        end
    end

    // Per-register increment/decrement requests and the illegal-writeback flag.
    always_comb begin
        inc_vec  = '0;
        dec_vec  = '0;
        err_next = 1'b0;
        if (bus.rsv_ack && (bus.rsv_reg != '0))
            inc_vec[bus.rsv_reg] = 1'b1;
        if (wb_valid) begin
            dec_vec[bus.write_reg] = 1'b1;
            err_next = (cnt[bus.write_reg] == 2'd0);
        end
    end

    // Scoreboard counters: a simultaneous hit from both sides cancels out, and a count of 0 never underflows.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREGS; r++)
                cnt[r] <= 2'd0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (inc_vec[r] && !dec_vec[r])
                    cnt[r] <= cnt[r] + 2'd1;
                else if (dec_vec[r] && !inc_vec[r] && (cnt[r] != 2'd0))
                    cnt[r] <= cnt[r] - 2'd1;
            end
        end
    end

    // Register data storage; an unexpected writeback still lands its data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREGS; r++)
                regs[r] <= '0;
        end else if (wb_valid) begin
            regs[bus.write_reg] <= bus.write_val;
        end
    end

    // One-cycle error pulse following a writeback that had nothing pending.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            bus.wr_err <= 1'b0;
        else
            bus.wr_err <= err_next;
    end

    // Combinational read ports with readiness taken from the scoreboard.
    always_comb begin
        bus.rd_val   = '0;
        bus.rd_ready = '1;
        rd_idx       = '0;
        for (int i = 0; i < NRD; i++) begin
            rd_idx = bus.rd_addr[i*AW +: AW];
            if (reset && (rd_idx != '0)) begin
                bus.rd_val[i*XLEN +: XLEN] = regs[rd_idx];
                bus.rd_ready[i]            = (cnt[rd_idx] == 2'd0);
`ifdef REG_FILE_BYPASS_EN
                if (bus.write_sig && (bus.write_reg == rd_idx)) begin
                    bus.rd_val[i*XLEN +: XLEN] = bus.write_val;
                    bus.rd_ready[i]            = (cnt[rd_idx] <= 2'd1);
                end
`endif
            end
        end
    end
endmodule
